// File: rtl/ntt_sched.sv
// ntt_sched: job sequencer for host load, ping-pong NTT stages and host unload
module ntt_sched #(
  parameter int N = 256,
  parameter int LOGN = 8,
  parameter int AW = 7,
  parameter int BFU_LAT = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic          ul_valid,
  input  logic          ul_ready,
  output logic          host_we,
  output logic          host_pair,
  output logic          host_bank,
  output logic [AW-1:0] host_addr,
  output logic          bfu_en,
  output logic [AW-1:0] rd_addr,
  output logic          rd_sel,
  output logic [4:0]    stage,
  output logic          stage_start
);
  localparam int DW = $clog2(BFU_LAT) + 1;
  localparam logic [LOGN-1:0] C_LAST = LOGN'(N - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N / 2 - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BFU_LAT - 1);
  localparam logic [4:0] S_LAST = 5'(LOGN);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, UNLOAD, DONE} state_t;
  state_t state, state_n;
  logic [LOGN-1:0] c, c_n;
  logic [AW-1:0] a_n;
  logic [4:0] stage_n;
  logic sel_n;
  logic [DW-1:0] d, d_n;
  assign host_bank = c[LOGN-1];
  assign host_addr = c[AW-1:0];
  assign host_we = ld_valid & ld_ready;
  // state and counters; status flags are registered from next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      c <= '0;
      rd_addr <= '0;
      stage <= '0;
      rd_sel <= 1'b0;
      d <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ld_ready <= 1'b0;
      ul_valid <= 1'b0;
      bfu_en <= 1'b0;
      stage_start <= 1'b0;
      host_pair <= 1'b0;
    end else begin
      state <= state_n;
      c <= c_n;
      rd_addr <= a_n;
      stage <= stage_n;
      rd_sel <= sel_n;
      d <= d_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      ld_ready <= state_n == LOAD;
      ul_valid <= state_n == UNLOAD;
      bfu_en <= state_n == RUN;
      stage_start <= state_n == RUN && a_n == '0;
      host_pair <= state_n == UNLOAD && sel_n;
    end
  end
  // next-state: load beats, per-stage issue sweep, drain wait, unload beats
  always_comb begin
    state_n = state;
    c_n = c;
    a_n = rd_addr;
    stage_n = stage;
    sel_n = rd_sel;
    d_n = d;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        c_n = '0;
      end
      LOAD: if (ld_valid) begin
        c_n = c + 1'b1;
        if (c == C_LAST) begin
          state_n = RUN;
          stage_n = 5'd1;
          sel_n = 1'b0;
          a_n = '0;
        end
      end
      RUN: begin
        a_n = rd_addr + 1'b1;
        if (rd_addr == A_LAST) begin
          state_n = DRAIN;
          d_n = '0;
        end
      end
      DRAIN: begin
        d_n = d + 1'b1;
        if (d == D_LAST) begin
          sel_n = !rd_sel;
          a_n = '0;
          if (stage == S_LAST) begin
            state_n = UNLOAD;
            c_n = '0;
            stage_n = '0;
          end else begin
            state_n = RUN;
            stage_n = stage + 5'd1;
          end
        end
      end
      UNLOAD: if (ul_ready) begin
        c_n = c + 1'b1;
        if (c == C_LAST) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        sel_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ntt_sched.sv
// tb_ntt_sched: randomized scenario bench for ntt_sched against a trace model
module tb_ntt_sched;
  localparam int N = 16, LOGN = 4, AW = 3, BL = 2;
  localparam int JOB_CYC = 16 + 40 + 16 + 2;
  logic clk = 0, reset = 1, start = 0, ld_valid = 0, ul_ready = 0;
  logic busy, done, ld_ready, ul_valid, host_we, host_pair, host_bank, bfu_en, rd_sel, stage_start;
  logic [AW-1:0] host_addr, rd_addr;
  logic [4:0] stage;
  logic start2 = 0, ld_valid2 = 0, ul_ready2 = 0;
  logic busy2, done2, ld_ready2, ul_valid2, host_we2, host_pair2, host_bank2, bfu_en2, rd_sel2, stage_start2;
  logic [1:0] host_addr2, rd_addr2;
  logic [4:0] stage2;
  int pass_n = 0, total_n = 0;
  typedef struct {bit en; int st; int a; bit sel; bit ss;} run_t;
  run_t rr_q[$], exp_q[$];
  int ld_q[$], ul_q[$], pr_q[$], hold_q[$];
  int done_n, done_cyc, ss_n;
  bit busy_after, sel_after;

  always #5 clk = ~clk;

  ntt_sched #(.N(N), .LOGN(LOGN), .AW(AW), .BFU_LAT(BL)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ul_valid(ul_valid), .ul_ready(ul_ready),
    .host_we(host_we), .host_pair(host_pair), .host_bank(host_bank), .host_addr(host_addr),
    .bfu_en(bfu_en), .rd_addr(rd_addr), .rd_sel(rd_sel), .stage(stage), .stage_start(stage_start)
  );

  ntt_sched #(.N(8), .LOGN(3), .AW(2), .BFU_LAT(BL)) u_odd (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ul_valid(ul_valid2), .ul_ready(ul_ready2),
    .host_we(host_we2), .host_pair(host_pair2), .host_bank(host_bank2), .host_addr(host_addr2),
    .bfu_en(bfu_en2), .rd_addr(rd_addr2), .rd_sel(rd_sel2), .stage(stage2), .stage_start(stage_start2)
  );

  task automatic build_expected();
    exp_q.delete();
    for (int s = 1; s <= LOGN; s++) begin
      for (int a = 0; a < N / 2; a++) exp_q.push_back('{1'b1, s, a, bit'((s - 1) % 2), bit'(a == 0)});
      for (int d = 0; d < BL; d++) exp_q.push_back('{1'b0, s, 0, bit'((s - 1) % 2), 1'b0});
    end
  endtask

  task automatic run_job(input int ld_pct, input bit ul_stall, input bit extra);
    int k = 0, stall_left = 0;
    bit stalled = 0;
    ld_q.delete(); ul_q.delete(); pr_q.delete(); hold_q.delete(); rr_q.delete();
    done_n = 0; done_cyc = -1; ss_n = 0; busy_after = 1; sel_after = 1;
    while (done_cyc < 0 || k <= done_cyc + 3) begin
      @(negedge clk);
      if (ul_stall && !stalled && ul_valid && {host_bank, host_addr} == 4'd9) begin
        stall_left = 5;
        stalled = 1;
      end
      if (stall_left > 0) begin
        hold_q.push_back(int'({host_bank, host_addr}));
        stall_left--;
        ul_ready = 0;
      end else ul_ready = 1;
      ld_valid = ($urandom_range(99) < ld_pct);
      start = (k == 0) || (extra && (k == 5 || k == 30));
      #1;
      if (host_we) ld_q.push_back(int'({host_bank, host_addr}));
      if (ul_valid && ul_ready) begin
        ul_q.push_back(int'({host_bank, host_addr}));
        pr_q.push_back(int'(host_pair));
      end
      if (busy && !ld_ready && !ul_valid && !done)
        rr_q.push_back('{bfu_en, int'(stage), int'(rd_addr), rd_sel, stage_start});
      if (stage_start) ss_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        busy_after = busy;
        sel_after = rd_sel;
      end
      k++;
      if (k > 4000) begin
        total_n++;
        $display("FAIL job_timeout cycles=%0d want done", k);
        break;
      end
    end
    start = 0; ld_valid = 0; ul_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_n++;
    if ({busy, done, ld_ready, ul_valid, host_we, host_pair, host_bank, host_addr, bfu_en, rd_addr, rd_sel, stage, stage_start} !== '0)
      $display("FAIL reset_outputs got busy=%b ld_ready=%b bfu_en=%b stage=%0d want all 0", busy, ld_ready, bfu_en, stage);
    else pass_n++;
    total_n++;
    if ({busy2, done2, ld_ready2, ul_valid2, host_pair2, bfu_en2, rd_sel2, stage2} !== '0)
      $display("FAIL reset_outputs_odd got busy=%b stage=%0d want 0", busy2, stage2);
    else pass_n++;
    reset = 0;
  endtask

  task automatic test_basic();
    run_job(100, 0, 0);
    total_n++;
    if (ld_q.size() != N) $display("FAIL basic_ld_count got %0d want %0d", ld_q.size(), N); else pass_n++;
    for (int i = 0; i < ld_q.size() && i < N; i++) begin
      total_n++;
      if (ld_q[i] != i) $display("FAIL basic_ld_addr beat %0d got %0d want %0d", i, ld_q[i], i); else pass_n++;
    end
    build_expected();
    total_n++;
    if (rr_q.size() != exp_q.size()) $display("FAIL basic_run_len got %0d want %0d", rr_q.size(), exp_q.size()); else pass_n++;
    for (int i = 0; i < rr_q.size() && i < exp_q.size(); i++) begin
      total_n++;
      if (rr_q[i].en !== exp_q[i].en || rr_q[i].st != exp_q[i].st || rr_q[i].ss !== exp_q[i].ss ||
          rr_q[i].sel !== exp_q[i].sel || (exp_q[i].en && rr_q[i].a != exp_q[i].a))
        $display("FAIL basic_run cyc %0d got en=%b st=%0d a=%0d sel=%b ss=%b want en=%b st=%0d a=%0d sel=%b ss=%b",
                 i, rr_q[i].en, rr_q[i].st, rr_q[i].a, rr_q[i].sel, rr_q[i].ss,
                 exp_q[i].en, exp_q[i].st, exp_q[i].a, exp_q[i].sel, exp_q[i].ss);
      else pass_n++;
    end
    total_n++;
    if (ul_q.size() != N) $display("FAIL basic_ul_count got %0d want %0d", ul_q.size(), N); else pass_n++;
    for (int i = 0; i < ul_q.size() && i < N; i++) begin
      total_n++;
      if (ul_q[i] != i || pr_q[i] != LOGN % 2)
        $display("FAIL basic_ul beat %0d got addr=%0d pair=%0d want addr=%0d pair=%0d", i, ul_q[i], pr_q[i], i, LOGN % 2);
      else pass_n++;
    end
    total_n++;
    if (done_n != 1) $display("FAIL basic_done_count got %0d want 1", done_n); else pass_n++;
    total_n++;
    if (done_cyc + 1 != JOB_CYC) $display("FAIL basic_job_cycles got %0d want %0d", done_cyc + 1, JOB_CYC); else pass_n++;
    total_n++;
    if (ss_n != LOGN) $display("FAIL basic_stage_starts got %0d want %0d", ss_n, LOGN); else pass_n++;
    total_n++;
    if (busy_after !== 1'b0 || sel_after !== 1'b0)
      $display("FAIL basic_idle_after got busy=%b rd_sel=%b want 0 0", busy_after, sel_after);
    else pass_n++;
  endtask

  task automatic test_stalls();
    run_job(50, 1, 0);
    total_n++;
    if (ld_q.size() != N) $display("FAIL stall_ld_count got %0d want %0d", ld_q.size(), N); else pass_n++;
    for (int i = 0; i < ld_q.size() && i < N; i++) begin
      total_n++;
      if (ld_q[i] != i) $display("FAIL stall_ld_addr beat %0d got %0d want %0d", i, ld_q[i], i); else pass_n++;
    end
    total_n++;
    if (ul_q.size() != N) $display("FAIL stall_ul_count got %0d want %0d", ul_q.size(), N); else pass_n++;
    for (int i = 0; i < ul_q.size() && i < N; i++) begin
      total_n++;
      if (ul_q[i] != i) $display("FAIL stall_ul_addr beat %0d got %0d want %0d", i, ul_q[i], i); else pass_n++;
    end
    total_n++;
    if (hold_q.size() != 5) $display("FAIL stall_hold_len got %0d want 5", hold_q.size()); else pass_n++;
    foreach (hold_q[i]) begin
      total_n++;
      if (hold_q[i] != 9) $display("FAIL stall_hold cyc %0d got %0d want 9 (bank 1 addr 1)", i, hold_q[i]); else pass_n++;
    end
    total_n++;
    if (done_n != 1) $display("FAIL stall_done_count got %0d want 1", done_n); else pass_n++;
  endtask

  task automatic test_odd_logn();
    int beats = 0, bad = 0;
    bit seen = 0;
    @(negedge clk);
    start2 = 1; ld_valid2 = 1; ul_ready2 = 1;
    @(negedge clk);
    start2 = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (ul_valid2 && ul_ready2) begin
        beats++;
        if (host_pair2 !== 1'b1) bad++;
      end
      if (done2) seen = 1;
    end
    ld_valid2 = 0; ul_ready2 = 0;
    total_n++;
    if (!seen) $display("FAIL odd_done got none want 1 pulse"); else pass_n++;
    total_n++;
    if (beats != 8) $display("FAIL odd_ul_count got %0d want 8", beats); else pass_n++;
    total_n++;
    if (bad != 0) $display("FAIL odd_host_pair got %0d beats not pair 1 want 0", bad); else pass_n++;
  endtask

  task automatic test_start_busy();
    run_job(100, 0, 1);
    total_n++;
    if (done_n != 1) $display("FAIL busy_start_done got %0d want 1", done_n); else pass_n++;
    total_n++;
    if (done_cyc + 1 != JOB_CYC) $display("FAIL busy_start_cycles got %0d want %0d", done_cyc + 1, JOB_CYC); else pass_n++;
    total_n++;
    if (ld_q.size() != N || ss_n != LOGN)
      $display("FAIL busy_start_counts got ld=%0d ss=%0d want %0d %0d", ld_q.size(), ss_n, N, LOGN);
    else pass_n++;
  endtask

  task automatic test_reset_mid_run();
    bit hit = 0;
    @(negedge clk);
    start = 1; ld_valid = 1; ul_ready = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (stage == 5'd2 && rd_addr == 3'd5 && bfu_en) hit = 1;
    end
    total_n++;
    if (!hit) $display("FAIL midrun_reach got stage=%0d addr=%0d want stage 2 addr 5", stage, rd_addr); else pass_n++;
    reset = 1;
    @(negedge clk);
    total_n++;
    if ({busy, done, ld_ready, ul_valid, host_we, host_pair, host_bank, host_addr, bfu_en, rd_addr, rd_sel, stage, stage_start} !== '0)
      $display("FAIL midrun_reset_outputs got busy=%b bfu_en=%b stage=%0d rd_addr=%0d want all 0", busy, bfu_en, stage, rd_addr);
    else pass_n++;
    reset = 0; ld_valid = 0; ul_ready = 0;
    run_job(100, 0, 0);
    build_expected();
    total_n++;
    if (done_n != 1 || done_cyc + 1 != JOB_CYC)
      $display("FAIL midrun_rerun_done got n=%0d cycles=%0d want 1 %0d", done_n, done_cyc + 1, JOB_CYC);
    else pass_n++;
    total_n++;
    if (ld_q.size() != N || ul_q.size() != N || rr_q.size() != exp_q.size() || ss_n != LOGN)
      $display("FAIL midrun_rerun_counts got ld=%0d ul=%0d run=%0d ss=%0d want %0d %0d %0d %0d",
               ld_q.size(), ul_q.size(), rr_q.size(), ss_n, N, N, exp_q.size(), LOGN);
    else pass_n++;
    for (int i = 0; i < rr_q.size() && i < exp_q.size(); i++) begin
      total_n++;
      if (rr_q[i].en !== exp_q[i].en || rr_q[i].st != exp_q[i].st || rr_q[i].sel !== exp_q[i].sel ||
          (exp_q[i].en && rr_q[i].a != exp_q[i].a))
        $display("FAIL midrun_rerun_run cyc %0d got en=%b st=%0d a=%0d sel=%b want en=%b st=%0d a=%0d sel=%b",
                 i, rr_q[i].en, rr_q[i].st, rr_q[i].a, rr_q[i].sel, exp_q[i].en, exp_q[i].st, exp_q[i].a, exp_q[i].sel);
      else pass_n++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_odd_logn();
    test_start_busy();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
